// File: rtl/sdm_dac_pkg.sv
// Shared constants for the sdm_dac modulator and its optional dither source.
// The dither LFSR is only built when SDM_DAC_DITHER_EN is defined.
`ifndef SDM_DAC_PKG_SV
`define SDM_DAC_PKG_SV

package sdm_dac_pkg;

  // Error registers carry this many bits above the sample width.
  localparam int ACC_MARGIN = 4;

  // Maximal-length 16-bit LFSR: x^16 + x^15 + x^13 + x^4 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

`endif

// File: rtl/sdm_dac_lfsr_dither.sv
// Pseudo-random +/-1 dither bit for sdm_dac; compiled only with SDM_DAC_DITHER_EN.
`ifdef SDM_DAC_DITHER_EN
module lfsr_dither
  import sdm_dac_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LFSR_SEED;
    end else if (i_en) begin
      state <= lfsr_next(state);
    end
  end

  assign o_bit = state[0];

endmodule
`endif

// File: rtl/sdm_dac.sv
// Second-order error-feedback delta-sigma DAC with zero-order-hold sample request.
// Define SDM_DAC_DITHER_EN to add LFSR dither ahead of the quantiser.
module sdm_dac
  import sdm_dac_pkg::*;
#(
  parameter int I_WIDTH   = 16,
  parameter int OSR_BITS  = 4,
  parameter int ACC_WIDTH = I_WIDTH + ACC_MARGIN
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [I_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_sd,
  output logic               o_underrun,
  output logic               o_overload
);

  localparam int W_WIDTH = ACC_WIDTH + 2;

  localparam logic signed [W_WIDTH-1:0] FS =
    {{(W_WIDTH-I_WIDTH){1'b0}}, 1'b1, {(I_WIDTH-1){1'b0}}};
  localparam logic signed [W_WIDTH-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] ACC_MIN = {3'b111, {(ACC_WIDTH-1){1'b0}}};

  // o_ready is registered, so it is raised one count early.
  localparam logic [OSR_BITS-1:0] READY_PRE = OSR_BITS'((1 << OSR_BITS) - 2);

  logic [OSR_BITS-1:0]         cnt;
  logic signed [I_WIDTH-1:0]   x_hold;
  logic signed [ACC_WIDTH-1:0] e1, e2, e_sat;
  logic signed [W_WIDTH-1:0]   w, v, e;
  logic                        q, clamp;

`ifdef SDM_DAC_DITHER_EN
  localparam logic signed [W_WIDTH-1:0] DITHER_STEP =
    W_WIDTH'(1) << (ACC_WIDTH - I_WIDTH - 2);

  logic dither_bit;

  lfsr_dither u_dither (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .o_bit (dither_bit)
  );
`endif

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    w = W_WIDTH'(x_hold) + (W_WIDTH'(e1) <<< 1) - W_WIDTH'(e2);
`ifdef SDM_DAC_DITHER_EN
    w = w + (dither_bit ? DITHER_STEP : -DITHER_STEP);
`endif
    q     = (w >= 0);
    v     = q ? FS : -FS;
    e     = w - v;
    clamp = 1'b1;
    if (e > ACC_MAX) begin
      e_sat = ACC_MAX[ACC_WIDTH-1:0];
    end else if (e < ACC_MIN) begin
      e_sat = ACC_MIN[ACC_WIDTH-1:0];
    end else begin
      e_sat = e[ACC_WIDTH-1:0];
      clamp = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      x_hold     <= '0;
      e1         <= '0;
      e2         <= '0;
      o_ready    <= 1'b0;
      o_sd       <= 1'b0;
      o_underrun <= 1'b0;
      o_overload <= 1'b0;
    end else if (i_en) begin
      cnt        <= cnt + OSR_BITS'(1);
      o_ready    <= (cnt == READY_PRE);
      o_underrun <= o_ready && !i_valid;
      if (o_ready && i_valid) begin
        x_hold <= i_data;
      end
      o_sd <= q;
      e2   <= e1;
      e1   <= e_sat;
      if (clamp) begin
        o_overload <= 1'b1;
      end
    end else begin
      o_underrun <= 1'b0;
    end
  end

endmodule
